// File: rtl/ra_wport_arb_if.sv
// ----------------------------------------------------------------------------
// ra_wport_arb_if
//
// Purpose: bundles every bus-level signal of the register-file write-port
// arbiter so that the arbiter and its environment connect through one port.
//
// Signal summary (direction seen from the arbiter, i.e. the slave modport):
//   r0_valid/r0_ad/r0_d  in   ALU writeback request (valid, dest reg, data)
//   r0_ready             out  ALU request accepted this cycle
//   r1_valid/r1_ad/r1_d  in   load/IO writeback request
//   r1_ready             out  load/IO request accepted this cycle
//   rsv_valid/rsv_ad     in   issue stage reserves a destination register
//   qa/qb                in   source registers of the instruction in issue
//   hazard               out  qa or qb has a pending write
//   we/wad/wd            out  registered register-file write port
//   err                  out  sticky scoreboard over/underflow flag
// ----------------------------------------------------------------------------
interface ra_wport_arb_if #(
    parameter int DW = 16,
    parameter int AW = 2
);
    logic          r0_valid;
    logic [AW-1:0] r0_ad;
    logic [DW-1:0] r0_d;
    logic          r0_ready;

    logic          r1_valid;
    logic [AW-1:0] r1_ad;
    logic [DW-1:0] r1_d;
    logic          r1_ready;

    logic          rsv_valid;
    logic [AW-1:0] rsv_ad;

    logic [AW-1:0] qa;
    logic [AW-1:0] qb;
    logic          hazard;

    logic          we;
    logic [AW-1:0] wad;
    logic [DW-1:0] wd;
    logic          err;

    // Arbiter side.
    modport slave (
        input  r0_valid, r0_ad, r0_d,
        input  r1_valid, r1_ad, r1_d,
        input  rsv_valid, rsv_ad,
        input  qa, qb,
        output r0_ready, r1_ready,
        output hazard,
        output we, wad, wd,
        output err
    );

    // Requesters / issue stage / register file side.
    modport master (
        output r0_valid, r0_ad, r0_d,
        output r1_valid, r1_ad, r1_d,
        output rsv_valid, rsv_ad,
        output qa, qb,
        input  r0_ready, r1_ready,
        input  hazard,
        input  we, wad, wd,
        input  err
    );
endinterface

// File: rtl/ra_wport_arb.sv
// ----------------------------------------------------------------------------
// ra_wport_arb
//
// Purpose: arbitrates two writeback requesters (ALU = r0, load/IO = r1) onto a
// single registered register-file write port, and keeps a small per-register
// scoreboard of pending writes used to flag read-after-write hazards for the
// instruction currently in issue.
//
// Ports:
//   clk   in   sole clock, all state changes on its rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of ra_wport_arb_if (requests, readies, reservation,
//              hazard query, write port, error flag)
//
// Behaviour overview:
//   * Grant: a lone valid requester wins; when both are valid a 1-bit
//     round-robin pointer picks the winner and then flips to the other one.
//     Uncontended grants leave the pointer alone.
//   * Write port: the accepted request appears on we/wad/wd one cycle later.
//     wad/wd hold their last value when nothing was accepted.
//   * Scoreboard: a 2-bit saturating count per register; a reservation
//     increments, an accepted write decrements, both together cancel.
//     Overflow at 3 or underflow at 0 leaves the count alone and sets the
//     sticky err flag.
// ----------------------------------------------------------------------------
module ra_wport_arb #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    ra_wport_arb_if.slave bus
);
    localparam int NREG = 2 ** AW;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // ptr_q == 0 favours r0 on contention, 1 favours r1.
    logic          ptr_q;
    logic          ptr_d;
    logic          gnt0;
    logic          gnt1;
    logic          contended;
    logic          hs;
    logic [AW-1:0] hs_ad;
    logic [DW-1:0] hs_d;

    always_comb begin
        contended = bus.r0_valid & bus.r1_valid;
        gnt0      = bus.r0_valid & (~bus.r1_valid | ~ptr_q);
        gnt1      = bus.r1_valid & (~bus.r0_valid |  ptr_q);
        hs        = gnt0 | gnt1;
        // gnt0 and gnt1 are mutually exclusive, so a simple select is enough.
        hs_ad     = gnt1 ? bus.r1_ad : bus.r0_ad;
        hs_d      = gnt1 ? bus.r1_d  : bus.r0_d;
        // Only a contended grant moves the pointer; it then favours the loser,
        // which bounds the wait of a continuously valid requester to 1 cycle.
        ptr_d     = contended ? ~ptr_q : ptr_q;
    end

    assign bus.r0_ready = gnt0;
    assign bus.r1_ready = gnt1;

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic          we_q;
    logic          we_d;
    logic [AW-1:0] wad_q;
    logic [AW-1:0] wad_d;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] wd_d;

    always_comb begin
        we_d  = hs;
        wad_d = hs ? hs_ad : wad_q;
        wd_d  = hs ? hs_d  : wd_q;
    end

    assign bus.we  = we_q;
    assign bus.wad = wad_q;
    assign bus.wd  = wd_q;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    logic [NREG-1:0][1:0] cnt_q;
    logic [NREG-1:0][1:0] cnt_d;
    logic [NREG-1:0]      inc;
    logic [NREG-1:0]      dec;
    logic [NREG-1:0]      err_set;
    logic                 err_q;
    logic                 err_d;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            assign inc[gi] = bus.rsv_valid && (bus.rsv_ad == AW'(gi));
            assign dec[gi] = hs && (hs_ad == AW'(gi));

            // A same-register reserve and write cancel out. Otherwise the count
            // saturates at 3 / floors at 0 and the attempt is reported as err.
            assign cnt_d[gi] =
                (inc[gi] && !dec[gi] && (cnt_q[gi] != 2'd3)) ? cnt_q[gi] + 2'd1 :
                (dec[gi] && !inc[gi] && (cnt_q[gi] != 2'd0)) ? cnt_q[gi] - 2'd1 :
                cnt_q[gi];

            assign err_set[gi] =
                (inc[gi] && !dec[gi] && (cnt_q[gi] == 2'd3)) ||
                (dec[gi] && !inc[gi] && (cnt_q[gi] == 2'd0));
        end
    endgenerate

    assign err_d   = err_q | (|err_set);
    assign bus.err = err_q;

    // Hazard looks only at registered counts, so a reservation or write in
    // the current cycle becomes visible one cycle later.
    assign bus.hazard = (cnt_q[bus.qa] != 2'd0) || (cnt_q[bus.qb] != 2'd0);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Reset discards any handshake or reservation of the same cycle because
    // the next-state values are simply ignored while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
            we_q  <= 1'b0;
            wad_q <= '0;
            wd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= we_d;
            wad_q <= wad_d;
            wd_q  <= wd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_ra_wport_arb.sv
// ----------------------------------------------------------------------------
// tb_ra_wport_arb
//
// Self-checking bench for ra_wport_arb. Directed scenarios check against
// literal expected values; a randomized phase checks against a cycle-level
// reference model built from the arbitration and scoreboard rules.
// ----------------------------------------------------------------------------
module tb_ra_wport_arb;
    localparam int DW = 16;
    localparam int AW = 2;

    logic clk;
    logic rst;

    ra_wport_arb_if #(.DW(DW), .AW(AW)) bus ();

    ra_wport_arb #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int       m_cnt [4];
    bit       m_ptr;          // 0: r0 wins next contention
    bit       m_err;
    bit       m_we;
    int       m_wad;
    int       m_wd;

    // Winner under the rules: lone valid wins, contention goes to favoured one.
    function automatic logic [1:0] model_grant();
        if (bus.r0_valid && bus.r1_valid)
            return m_ptr ? 2'b10 : 2'b01;
        return {bus.r1_valid, bus.r0_valid};
    endfunction

    function automatic bit model_hazard();
        return (m_cnt[bus.qa] != 0) || (m_cnt[bus.qb] != 0);
    endfunction

    task automatic drive(input logic r0v, input logic [1:0] r0a, input logic [15:0] r0d,
                         input logic r1v, input logic [1:0] r1a, input logic [15:0] r1d,
                         input logic rv, input logic [1:0] ra,
                         input logic [1:0] a, input logic [1:0] b);
        bus.r0_valid  = r0v; bus.r0_ad = r0a; bus.r0_d = r0d;
        bus.r1_valid  = r1v; bus.r1_ad = r1a; bus.r1_d = r1d;
        bus.rsv_valid = rv;  bus.rsv_ad = ra;
        bus.qa = a; bus.qb = b;
    endtask

    task automatic idle(input logic [1:0] a);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, a, a);
    endtask

    // One clock edge; the model absorbs the inputs present at that edge.
    task automatic tick();
        logic [1:0] g;
        bit         hs;
        int         ad;
        int         d;
        bit         both;
        bit         rv;
        int         ra;
        g    = model_grant();
        hs   = (g != 2'b00);
        ad   = g[1] ? int'(bus.r1_ad) : int'(bus.r0_ad);
        d    = g[1] ? int'(bus.r1_d)  : int'(bus.r0_d);
        both = bus.r0_valid && bus.r1_valid;
        rv   = bus.rsv_valid;
        ra   = int'(bus.rsv_ad);
        @(posedge clk);
        if (rst) begin
            m_we = 0; m_wad = 0; m_wd = 0; m_err = 0; m_ptr = 0;
            for (int r = 0; r < 4; r++) m_cnt[r] = 0;
        end else begin
            m_we = hs;
            if (hs) begin
                m_wad = ad;
                m_wd  = d;
            end
            if (!(rv && hs && ra == ad)) begin
                if (rv) begin
                    if (m_cnt[ra] == 3) m_err = 1;
                    else m_cnt[ra]++;
                end
                if (hs) begin
                    if (m_cnt[ad] == 0) m_err = 1;
                    else m_cnt[ad]--;
                end
            end
            if (both) m_ptr = !m_ptr;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 3, 3, 1);
        tick();
        tick();
        #2;
        checks++; if (bus.we !== 1'b0)  begin errors++; $display("FAIL reset_we got %b want 0", bus.we); end
        checks++; if (bus.wad !== 2'd0) begin errors++; $display("FAIL reset_wad got %0d want 0", bus.wad); end
        checks++; if (bus.wd !== 16'h0) begin errors++; $display("FAIL reset_wd got %h want 0000", bus.wd); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", bus.hazard); end
        checks++; if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got r0=%b r1=%b want r0=1 r1=0", bus.r0_ready, bus.r1_ready);
        end
        rst = 1'b0;
        idle(0);
        tick();
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_discard_we got %b want 0", bus.we); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 2, 16'h1234, 0, 0, 16'h0, 0, 0, 0, 0);
        #2;
        checks++; if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got r0=%b r1=%b want r0=1 r1=0", bus.r0_ready, bus.r1_ready);
        end
        tick();
        idle(0);
        #2;
        checks++; if (bus.we !== 1'b1 || bus.wad !== 2'd2 || bus.wd !== 16'h1234) begin
            errors++; $display("FAIL single_write got we=%b wad=%0d wd=%h want we=1 wad=2 wd=1234", bus.we, bus.wad, bus.wd);
        end
        tick();
        checks++; if (bus.we !== 1'b0 || bus.wad !== 2'd2 || bus.wd !== 16'h1234) begin
            errors++; $display("FAIL single_hold got we=%b wad=%0d wd=%h want we=0 wad=2 wd=1234", bus.we, bus.wad, bus.wd);
        end
        $display("test_single done");
    endtask

    task automatic test_contention();
        logic [15:0] d0;
        logic [15:0] d1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d0 = 16'h0A00 + 16'(k);
            d1 = 16'h0B00 + 16'(k);
            drive(1, 1, d0, 1, 3, d1, 0, 0, 0, 0);
            #2;
            checks++; if (bus.r0_ready !== (k % 2 == 0) || bus.r1_ready !== (k % 2 == 1)) begin
                errors++; $display("FAIL contend_grant%0d got r0=%b r1=%b want r0=%0d r1=%0d",
                                   k, bus.r0_ready, bus.r1_ready, k % 2 == 0, k % 2 == 1);
            end
            tick();
            checks++; if (bus.we !== 1'b1 || bus.wad !== ((k % 2 == 0) ? 2'd1 : 2'd3) ||
                          bus.wd !== ((k % 2 == 0) ? d0 : d1)) begin
                errors++; $display("FAIL contend_write%0d got we=%b wad=%0d wd=%h", k, bus.we, bus.wad, bus.wd);
            end
        end
        idle(0);
        tick();
        $display("test_contention done");
    endtask

    task automatic test_hazard();
        do_reset();
        drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 1, 1, 1);
        #2;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL hazard_same_cycle got %b want 0", bus.hazard); end
        tick();
        drive(0, 0, 16'h0, 1, 1, 16'h5555, 0, 0, 1, 0);
        #2;
        checks++; if (bus.hazard !== 1'b1 || bus.r1_ready !== 1'b1) begin
            errors++; $display("FAIL hazard_pending got hazard=%b r1_ready=%b want 1 1", bus.hazard, bus.r1_ready);
        end
        tick();
        idle(1);
        #2;
        checks++; if (bus.hazard !== 1'b0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL hazard_cleared got hazard=%b err=%b want 0 0", bus.hazard, bus.err);
        end
        $display("test_hazard done");
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0);
            tick();
            checks++; if (bus.err !== (k == 3)) begin
                errors++; $display("FAIL sat_err%0d got %b want %0d", k, bus.err, k == 3);
            end
        end
        // Reserve and write the same register together: count stays at 3.
        drive(1, 0, 16'hC0DE, 0, 0, 16'h0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 16'h0100 + 16'(k), 0, 0, 16'h0, 0, 0, 0, 0);
            #2;
            checks++; if (bus.hazard !== 1'b1) begin
                errors++; $display("FAIL sat_hazard%0d got %b want 1", k, bus.hazard);
            end
            tick();
        end
        idle(0);
        #2;
        checks++; if (bus.hazard !== 1'b0 || bus.err !== 1'b1) begin
            errors++; $display("FAIL sat_drained got hazard=%b err=%b want 0 1", bus.hazard, bus.err);
        end
        $display("test_saturate done");
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 16'h0, 1, 2, 16'hBEEF, 0, 0, 2, 2);
        tick();
        idle(2);
        #2;
        checks++; if (bus.we !== 1'b1 || bus.wad !== 2'd2 || bus.wd !== 16'hBEEF || bus.err !== 1'b1) begin
            errors++; $display("FAIL underflow got we=%b wad=%0d wd=%h err=%b want 1 2 beef 1", bus.we, bus.wad, bus.wd, bus.err);
        end
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL underflow_cnt got hazard=%b want 0", bus.hazard); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", bus.err); end
        do_reset();
        #2;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL underflow_reset got %b want 0", bus.err); end
        $display("test_underflow done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Contended grant goes to r0 and moves the pointer toward r1; also reserve r3.
        drive(1, 1, 16'h1, 1, 0, 16'h2, 1, 3, 3, 3);
        tick();
        // r1 still valid alone this cycle, it is accepted (cycle N).
        drive(0, 0, 16'h0, 1, 0, 16'h2, 0, 0, 3, 3);
        tick();
        rst = 1'b1;
        drive(1, 1, 16'h7, 1, 2, 16'h8, 1, 2, 3, 2);
        #2;
        checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got %b want 1", bus.we); end
        tick();
        rst = 1'b0;
        drive(1, 1, 16'h9, 1, 2, 16'hA, 0, 0, 3, 2);
        #2;
        checks++; if (bus.we !== 1'b0 || bus.hazard !== 1'b0) begin
            errors++; $display("FAIL midrst_state got we=%b hazard=%b want 0 0", bus.we, bus.hazard);
        end
        checks++; if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ptr got r0=%b r1=%b want r0=1 r1=0", bus.r0_ready, bus.r1_ready);
        end
        tick();
        idle(0);
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        bit          p0v = 0;
        bit          p1v = 0;
        logic [1:0]  p0a = 0;
        logic [1:0]  p1a = 0;
        logic [15:0] p0d = 0;
        logic [15:0] p1d = 0;
        logic [1:0]  g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!p0v && ($urandom % 3 == 0)) begin
                p0v = 1; p0a = 2'($urandom); p0d = 16'($urandom);
            end
            if (!p1v && ($urandom % 3 == 0)) begin
                p1v = 1; p1a = 2'($urandom); p1d = 16'($urandom);
            end
            rst = ($urandom % 60 == 0);
            drive(p0v, p0a, p0d, p1v, p1a, p1d, ($urandom % 3 == 0), 2'($urandom),
                  2'($urandom), 2'($urandom));
            #2;
            g = model_grant();
            checks++; if (bus.r0_ready !== g[0] || bus.r1_ready !== g[1]) begin
                errors++; $display("FAIL rand_ready%0d got r0=%b r1=%b want r0=%b r1=%b",
                                   i, bus.r0_ready, bus.r1_ready, g[0], g[1]);
            end
            checks++; if (bus.hazard !== model_hazard()) begin
                errors++; $display("FAIL rand_hazard%0d got %b want %b", i, bus.hazard, model_hazard());
            end
            if (g[0]) p0v = 0;
            if (g[1]) p1v = 0;
            tick();
            checks++; if (bus.we !== m_we || int'(bus.wad) != m_wad || int'(bus.wd) != m_wd || bus.err !== m_err) begin
                errors++; $display("FAIL rand_port%0d got we=%b wad=%0d wd=%h err=%b want we=%b wad=%0d wd=%h err=%b",
                                   i, bus.we, bus.wad, bus.wd, bus.err, m_we, m_wad, m_wd[15:0], m_err);
            end
        end
        rst = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        m_ptr = 0; m_err = 0; m_we = 0; m_wad = 0; m_wd = 0;
        for (int r = 0; r < 4; r++) m_cnt[r] = 0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_hazard();
        test_saturate();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ra_wport_arb.md
RA_WPORT_ARB -- requirements
Module: ra_wport_arb

Interface
REQ-001 SHALL have parameter DW, default 16, register data width in bits.
REQ-002 SHALL have parameter AW, default 2, register address width (2**AW registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port r0_valid  input  1  ALU writeback request.
REQ-006 SHALL have port r0_ad  input  AW  ALU destination register.
REQ-007 SHALL have port r0_d  input  DW  ALU write data.
REQ-008 SHALL have port r0_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have ports r1_valid, r1_ad, r1_d, r1_ready with the same widths and meanings for the load/IO writeback requester.
REQ-010 SHALL have port rsv_valid  input  1  issue stage reserves a destination register.
REQ-011 SHALL have port rsv_ad  input  AW  register being reserved.
REQ-012 SHALL have ports qa, qb  input  AW each  source registers of the instruction in issue.
REQ-013 SHALL have port hazard  output  1  qa or qb has a pending write.
REQ-014 SHALL have ports we (1), wad (AW), wd (DW)  output  registered write port driving the register file.
REQ-015 SHALL have port err  output  1  sticky scoreboard over/underflow flag.

Function
REQ-016 Handshake SHALL complete on requester n in a cycle when rn_valid and rn_ready are both 1; a requester SHALL hold valid, ad and d stable until accepted.
REQ-017 rn_ready SHALL be combinational and asserted only for the granted requester; at most one ready SHALL be 1 per cycle.
REQ-018 With one requester valid, that requester SHALL be granted.
REQ-019 With both valid, the requester indicated by a 1-bit round-robin pointer SHALL be granted, and the pointer SHALL then move to the other requester.
REQ-020 The pointer SHALL change only on a contended grant; uncontended grants leave it unchanged.
REQ-021 No requester SHALL wait more than one cycle while continuously valid.
REQ-022 On a handshake in cycle N, we=1 and wad/wd SHALL equal the accepted ad/d in cycle N+1, a latency of exactly 1.
REQ-023 we SHALL be 0 in any cycle following a cycle with no handshake; wad/wd SHALL hold their previous values then.
REQ-024 The block SHALL keep a 2-bit pending counter per register.
REQ-025 rsv_valid SHALL increment cnt[rsv_ad] at the edge.
REQ-026 A handshake SHALL decrement cnt[ad] of the accepted request at the edge.
REQ-027 When rsv and a handshake target the same register in the same cycle, that counter SHALL be unchanged.
REQ-028 rsv at count 3 without a same-register handshake SHALL leave the count at 3 and set err.
REQ-029 A handshake to a register with count 0 SHALL still write, leave the count at 0 and set err.
REQ-030 hazard SHALL be combinational: (cnt[qa]!=0) or (cnt[qb]!=0), using current counter values; same-cycle rsv/handshake SHALL NOT affect it until the next cycle.
REQ-031 err, once set, SHALL stay 1 until reset.

Reset
REQ-032 While rst=1 at a posedge: we=0, wad=0, wd=0, err=0, all counters 0, pointer favours r0; handshakes and reservations in that cycle SHALL be discarded.
REQ-033 Combinational outputs during and after reset SHALL reflect reset state (hazard=0 when counters are 0; ready follows REQ-017..019).
REQ-034 Reset asserted mid-operation SHALL drop any pending write so that we=0 on the next cycle, and SHALL discard all pending reservations.

Verification
REQ-035 Scenario: r0 only, ad=2, d=0x1234, cycle N -> r0_ready=1 in N; we=1, wad=2, wd=0x1234 in N+1; we=0 in N+2.
REQ-036 Scenario: both valid for 4 cycles after reset (r0 ad=1, r1 ad=3) -> grants r0, r1, r0, r1; we each cycle from cycle 2 with alternating wad 1, 3.
REQ-037 Scenario: rsv ad=1, then qa=1 -> hazard=1 next cycle; r1 write ad=1 accepted -> hazard=0 the cycle after acceptance.
REQ-038 Scenario: rsv ad=0 four consecutive cycles -> count saturates at 3 and err=1 from cycle 5; rsv and write to ad=0 in the same cycle -> count stays 3.
REQ-039 Scenario: write to ad=2 with count 0 -> we=1, wad=2 in the next cycle and err=1; err stays 1 until rst.
REQ-040 Scenario: handshake in cycle N with rst=1 in cycle N+1 -> we=0 in N+2, counters 0, and next contended grant goes to r0.
